ctr_rmw_2p: RTL and testbench

- Dual-lane read-modify-write counter-update engine.
- Sits directly upstream of the 2-write/2-read counter RAM and drives all four of its ports.
- Each lane accepts (addr, delta) increments, reads the counter, adds the delta, writes the result back and returns the new value.
- Forwarding and same-cycle merging hide the RAM's 1-cycle read latency, so back-to-back updates to one address are never lost; the block also zero-initialises the RAM after reset.

---
 rtl/ctr_rmw_2p.sv | 215 +++++++++++++++++++++
 tb/tb_ctr_rmw_2p.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_rmw_2p.sv
// ctr_rmw_2p
//   Dual-lane read-modify-write counter-update engine. It drives all four
//   ports of a 2-write/2-read counter RAM with a 1-cycle read latency. Each
//   lane takes an (addr, delta) request, reads the counter, adds the delta and
//   writes the sum back. The new value is also returned on the lane's output.
//   Forwarding from the previous cycle's writes, plus merging of same-cycle
//   same-address requests, keeps back-to-back updates from being lost. After
//   reset the block zeroes the whole RAM before it accepts any request.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   in{0,1}_val/rdy/addr/delta        request lanes (valid/ready)
//   out{0,1}_val/data                 updated counter value, 1-cycle pulse
//   r{0,1}_val/addr/data              RAM read ports (data one cycle later)
//   w{0,1}_val/addr/data              RAM write ports
//   init_done                         high once the RAM zeroing sweep is over
module ctr_rmw_2p #(
  parameter int RAM_DEPTH      = 64,
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int CNT_WIDTH      = 32,
  parameter int DELTA_WIDTH    = 16,
  parameter bit SATURATE       = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in0_val,
  output logic                      in0_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] in0_addr,
  input  logic [DELTA_WIDTH-1:0]    in0_delta,
  input  logic                      in1_val,
  output logic                      in1_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] in1_addr,
  input  logic [DELTA_WIDTH-1:0]    in1_delta,
  output logic                      out0_val,
  output logic [CNT_WIDTH-1:0]      out0_data,
  output logic                      out1_val,
  output logic [CNT_WIDTH-1:0]      out1_data,
  output logic                      r0_val,
  output logic [RAM_ADDR_WIDTH-1:0] r0_addr,
  input  logic [CNT_WIDTH-1:0]      r0_data,
  output logic                      r1_val,
  output logic [RAM_ADDR_WIDTH-1:0] r1_addr,
  input  logic [CNT_WIDTH-1:0]      r1_data,
  output logic                      w0_val,
  output logic [RAM_ADDR_WIDTH-1:0] w0_addr,
  output logic [CNT_WIDTH-1:0]      w0_data,
  output logic                      w1_val,
  output logic [RAM_ADDR_WIDTH-1:0] w1_addr,
  output logic [CNT_WIDTH-1:0]      w1_data,
  output logic                      init_done
);

  localparam int HALF = (RAM_DEPTH + 1) / 2;
  localparam logic [RAM_ADDR_WIDTH-1:0] K_LAST = RAM_ADDR_WIDTH'(HALF - 1);

  typedef logic [CNT_WIDTH:0] sum_t;
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    state_reg, state_next;
  logic [RAM_ADDR_WIDTH-1:0] k_reg, k_next;
  // Holds off the sweep for the first cycle after reset, so that cycle shows
  // no RAM activity at all.
  logic                      armed_reg;

  logic                      running;
  logic                      init_w;
  logic                      init_hi_ok;
  logic [RAM_ADDR_WIDTH-1:0] init_addr_lo, init_addr_hi;

  logic [1:0]                               in_val, acc, s1_v, fw_val, wr_val;
  logic [1:0][RAM_ADDR_WIDTH-1:0]           in_addr, s1_addr, fw_addr, wr_addr;
  logic [1:0][DELTA_WIDTH-1:0]              in_delta, s1_delta;
  logic [1:0][CNT_WIDTH-1:0]                rd_data, fw_data, wr_data, base;
  logic [CNT_WIDTH-1:0]                     upd0, upd1;
  logic                                     merge;

  // Zero-extended add, then either wrap (drop the carry) or clamp at all-ones.
  function automatic logic [CNT_WIDTH-1:0] add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [DELTA_WIDTH-1:0] d);
    sum_t sum;
    sum = {1'b0, a} + sum_t'(d);
    if (SATURATE && sum[CNT_WIDTH]) add_cnt = '1;
    else                            add_cnt = sum[CNT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_INIT;
      k_reg     <= '0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      armed_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    if (state_reg == ST_INIT && armed_reg) begin
      k_next = k_reg + 1'b1;
      if (k_reg == K_LAST) begin
        state_next = ST_RUN;
        k_next     = '0;
      end
    end
  end

  // Every output is gated by rst so that nothing leaks out of the pipeline
  // while reset is being applied.
  assign running      = (state_reg == ST_RUN) && !rst;
  assign init_w       = (state_reg == ST_INIT) && armed_reg && !rst;
  assign init_addr_lo = k_reg << 1;
  assign init_addr_hi = init_addr_lo | RAM_ADDR_WIDTH'(1);
  // An odd depth leaves the final sweep step without an upper word.
  assign init_hi_ok   = (32'(k_reg) * 32'd2 + 32'd1) < 32'(RAM_DEPTH);

  assign init_done = running;
  assign in0_rdy   = running;
  assign in1_rdy   = running;

  // ---------------------------------------------------------------- lanes
  assign in_val   = {in1_val, in0_val};
  assign in_addr  = {in1_addr, in0_addr};
  assign in_delta = {in1_delta, in0_delta};
  assign rd_data  = {r1_data, r0_data};
  assign acc      = in_val & {2{running}};
  assign wr_val   = {w1_val, w0_val};
  assign wr_addr  = {w1_addr, w0_addr};
  assign wr_data  = {w1_data, w0_data};

  assign r0_val  = acc[0];
  assign r0_addr = in0_addr;
  assign r1_val  = acc[1];
  assign r1_addr = in1_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic                      s1_val_reg;
      logic [RAM_ADDR_WIDTH-1:0] s1_addr_reg;
      logic [DELTA_WIDTH-1:0]    s1_delta_reg;
      // Registered copy of this cycle's write on port gi: the RAM read that
      // was issued alongside it cannot see it yet.
      logic                      fw_val_reg;
      logic [RAM_ADDR_WIDTH-1:0] fw_addr_reg;
      logic [CNT_WIDTH-1:0]      fw_data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_val_reg   <= 1'b0;
          s1_addr_reg  <= '0;
          s1_delta_reg <= '0;
          fw_val_reg   <= 1'b0;
          fw_addr_reg  <= '0;
          fw_data_reg  <= '0;
        end else begin
          s1_val_reg   <= acc[gi];
          s1_addr_reg  <= in_addr[gi];
          s1_delta_reg <= in_delta[gi];
          fw_val_reg   <= wr_val[gi];
          fw_addr_reg  <= wr_addr[gi];
          fw_data_reg  <= wr_data[gi];
        end
      end

      assign s1_v[gi]     = s1_val_reg & ~rst;
      assign s1_addr[gi]  = s1_addr_reg;
      assign s1_delta[gi] = s1_delta_reg;
      assign fw_val[gi]   = fw_val_reg;
      assign fw_addr[gi]  = fw_addr_reg;
      assign fw_data[gi]  = fw_data_reg;

      // The two write ports never share an address, so at most one hits.
      assign base[gi] = (fw_val[0] && fw_addr[0] == s1_addr_reg) ? fw_data[0] :
                        (fw_val[1] && fw_addr[1] == s1_addr_reg) ? fw_data[1] :
                                                                   rd_data[gi];
    end
  endgenerate

  // Same-address pair: lane 0 is ordered first, so lane 1 builds on lane 0's
  // result and only one combined write goes out, on port 0.
  assign merge = s1_v[0] && s1_v[1] && (s1_addr[0] == s1_addr[1]);
  assign upd0  = add_cnt(base[0], s1_delta[0]);
  assign upd1  = merge ? add_cnt(upd0, s1_delta[1]) : add_cnt(base[1], s1_delta[1]);

  assign out0_val  = s1_v[0];
  assign out0_data = upd0;
  assign out1_val  = s1_v[1];
  assign out1_data = upd1;

  always_comb begin
    w0_val  = 1'b0;
    w0_addr = s1_addr[0];
    w0_data = upd0;
    w1_val  = 1'b0;
    w1_addr = s1_addr[1];
    w1_data = upd1;
    if (init_w) begin
      w0_val  = 1'b1;
      w0_addr = init_addr_lo;
      w0_data = '0;
      w1_val  = init_hi_ok;
      w1_addr = init_addr_hi;
      w1_data = '0;
    end else begin
      w0_val = s1_v[0];
      if (merge) w0_data = upd1;
      w1_val = s1_v[1] && !merge;
    end
  end

endmodule

// File: tb/tb_ctr_rmw_2p.sv
// Bench for ctr_rmw_2p: a 64-deep 32-bit instance, plus two 7-deep 8-bit
// instances (saturating and wrapping) that share one stimulus. Each instance
// is backed by a behavioural RAM.
module tb_ctr_rmw_2p;
  localparam int D = 64, AW = 6, CW = 32, DW = 16;
  localparam int SD = 7, SAW = 3, SCW = 8, SDW = 8;
  localparam int NV = 8, NR = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // ---------------- main instance
  logic          in0_val, in0_rdy, in1_val, in1_rdy;
  logic [AW-1:0] in0_addr, in1_addr;
  logic [DW-1:0] in0_delta, in1_delta;
  logic          out0_val, out1_val;
  logic [CW-1:0] out0_data, out1_data;
  logic          r0_val, r1_val;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [CW-1:0] r0_data, r1_data;
  logic          w0_val, w1_val;
  logic [AW-1:0] w0_addr, w1_addr;
  logic [CW-1:0] w0_data, w1_data;
  logic          init_done;
  logic [CW-1:0] ram_m [D];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [CW-1:0] poke_data = '0;

  ctr_rmw_2p #(.RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW), .CNT_WIDTH(CW),
               .DELTA_WIDTH(DW), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_delta(in0_delta),
    .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_delta(in1_delta),
    .out0_val(out0_val), .out0_data(out0_data), .out1_val(out1_val), .out1_data(out1_data),
    .r0_val(r0_val), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_val(r1_val), .r1_addr(r1_addr), .r1_data(r1_data),
    .w0_val(w0_val), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_val(w1_val), .w1_addr(w1_addr), .w1_data(w1_data),
    .init_done(init_done));

  always @(posedge clk) begin
    if (w0_val) ram_m[w0_addr] <= w0_data;
    if (w1_val) ram_m[w1_addr] <= w1_data;
    if (poke_en) ram_m[poke_addr] <= poke_data;
    if (r0_val) r0_data <= ram_m[r0_addr];
    if (r1_val) r1_data <= ram_m[r1_addr];
  end

  // ---------------- small instances (shared inputs)
  logic           s_in0_val, s_in1_val;
  logic [SAW-1:0] s_in0_addr, s_in1_addr;
  logic [SDW-1:0] s_in0_delta, s_in1_delta;
  logic           s_poke_en = 1'b0;
  logic [SAW-1:0] s_poke_addr = '0;
  logic [SCW-1:0] s_poke_data = '0;

  logic           sa_in0_rdy, sa_in1_rdy, sa_out0_val, sa_out1_val;
  logic [SCW-1:0] sa_out0_data, sa_out1_data;
  logic           sa_r0_val, sa_r1_val, sa_w0_val, sa_w1_val, sa_init_done;
  logic [SAW-1:0] sa_r0_addr, sa_r1_addr, sa_w0_addr, sa_w1_addr;
  logic [SCW-1:0] sa_r0_data, sa_r1_data, sa_w0_data, sa_w1_data;
  logic [SCW-1:0] sa_ram [8];

  logic           wr_in0_rdy, wr_in1_rdy, wr_out0_val, wr_out1_val;
  logic [SCW-1:0] wr_out0_data, wr_out1_data;
  logic           wr_r0_val, wr_r1_val, wr_w0_val, wr_w1_val, wr_init_done;
  logic [SAW-1:0] wr_r0_addr, wr_r1_addr, wr_w0_addr, wr_w1_addr;
  logic [SCW-1:0] wr_r0_data, wr_r1_data, wr_w0_data, wr_w1_data;
  logic [SCW-1:0] wr_ram [8];

  ctr_rmw_2p #(.RAM_DEPTH(SD), .RAM_ADDR_WIDTH(SAW), .CNT_WIDTH(SCW),
               .DELTA_WIDTH(SDW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .in0_val(s_in0_val), .in0_rdy(sa_in0_rdy), .in0_addr(s_in0_addr), .in0_delta(s_in0_delta),
    .in1_val(s_in1_val), .in1_rdy(sa_in1_rdy), .in1_addr(s_in1_addr), .in1_delta(s_in1_delta),
    .out0_val(sa_out0_val), .out0_data(sa_out0_data), .out1_val(sa_out1_val), .out1_data(sa_out1_data),
    .r0_val(sa_r0_val), .r0_addr(sa_r0_addr), .r0_data(sa_r0_data),
    .r1_val(sa_r1_val), .r1_addr(sa_r1_addr), .r1_data(sa_r1_data),
    .w0_val(sa_w0_val), .w0_addr(sa_w0_addr), .w0_data(sa_w0_data),
    .w1_val(sa_w1_val), .w1_addr(sa_w1_addr), .w1_data(sa_w1_data),
    .init_done(sa_init_done));

  ctr_rmw_2p #(.RAM_DEPTH(SD), .RAM_ADDR_WIDTH(SAW), .CNT_WIDTH(SCW),
               .DELTA_WIDTH(SDW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst),
    .in0_val(s_in0_val), .in0_rdy(wr_in0_rdy), .in0_addr(s_in0_addr), .in0_delta(s_in0_delta),
    .in1_val(s_in1_val), .in1_rdy(wr_in1_rdy), .in1_addr(s_in1_addr), .in1_delta(s_in1_delta),
    .out0_val(wr_out0_val), .out0_data(wr_out0_data), .out1_val(wr_out1_val), .out1_data(wr_out1_data),
    .r0_val(wr_r0_val), .r0_addr(wr_r0_addr), .r0_data(wr_r0_data),
    .r1_val(wr_r1_val), .r1_addr(wr_r1_addr), .r1_data(wr_r1_data),
    .w0_val(wr_w0_val), .w0_addr(wr_w0_addr), .w0_data(wr_w0_data),
    .w1_val(wr_w1_val), .w1_addr(wr_w1_addr), .w1_data(wr_w1_data),
    .init_done(wr_init_done));

  always @(posedge clk) begin
    if (sa_w0_val) sa_ram[sa_w0_addr] <= sa_w0_data;
    if (sa_w1_val) sa_ram[sa_w1_addr] <= sa_w1_data;
    if (wr_w0_val) wr_ram[wr_w0_addr] <= wr_w0_data;
    if (wr_w1_val) wr_ram[wr_w1_addr] <= wr_w1_data;
    if (s_poke_en) begin
      sa_ram[s_poke_addr] <= s_poke_data;
      wr_ram[s_poke_addr] <= s_poke_data;
    end
    if (sa_r0_val) sa_r0_data <= sa_ram[sa_r0_addr];
    if (sa_r1_val) sa_r1_data <= sa_ram[sa_r1_addr];
    if (wr_r0_val) wr_r0_data <= wr_ram[wr_r0_addr];
    if (wr_r1_val) wr_r1_data <= wr_ram[wr_r1_addr];
  end

  wire [8:0] m_ctl  = {in0_rdy, in1_rdy, out0_val, out1_val, r0_val, r1_val,
                       w0_val, w1_val, init_done};
  wire [8:0] sa_ctl = {sa_in0_rdy, sa_in1_rdy, sa_out0_val, sa_out1_val, sa_r0_val,
                       sa_r1_val, sa_w0_val, sa_w1_val, sa_init_done};
  wire [8:0] wr_ctl = {wr_in0_rdy, wr_in1_rdy, wr_out0_val, wr_out1_val, wr_r0_val,
                       wr_r1_val, wr_w0_val, wr_w1_val, wr_init_done};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic drive(input logic v0, input int a0, input int d0,
                       input logic v1, input int a1, input int d1);
    in0_val = v0; in0_addr = AW'(a0); in0_delta = DW'(d0);
    in1_val = v1; in1_addr = AW'(a1); in1_delta = DW'(d1);
  endtask

  task automatic s_drive(input logic v0, input int a0, input int d0,
                         input logic v1, input int a1, input int d1);
    s_in0_val = v0; s_in0_addr = SAW'(a0); s_in0_delta = SDW'(d0);
    s_in1_val = v1; s_in1_addr = SAW'(a1); s_in1_delta = SDW'(d1);
  endtask

  typedef struct {
    logic        v0;
    int          a0;
    int          d0;
    logic        v1;
    int          a1;
    int          d1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ew1;
  } vec_t;

  vec_t vt [NV];
  logic [CW-1:0] mdl [D];

  initial begin
    logic p0v, p1v;
    logic [CW-1:0] p0d, p1d;
    logic v0, v1;
    int a0, a1, d0, d1, cyc, nz;
    bit mrg;

    // Counters start at zero after the init sweep; entries run back to back.
    vt[0] = '{1'b1,  5, 3,     1'b0,  0,  0,  32'd3,     32'd0,     1'b0};
    vt[1] = '{1'b0,  0, 0,     1'b1,  5, 10,  32'd0,     32'd13,    1'b1};
    vt[2] = '{1'b1,  2, 4,     1'b1,  2,  6,  32'd4,     32'd10,    1'b0};
    vt[3] = '{1'b1,  2, 1,     1'b1,  2,  1,  32'd11,    32'd12,    1'b0};
    vt[4] = '{1'b1,  0, 65535, 1'b1, 63,  1,  32'd65535, 32'd1,     1'b1};
    vt[5] = '{1'b1,  0, 1,     1'b1,  5,  2,  32'd65536, 32'd15,    1'b1};
    vt[6] = '{1'b1, 63, 5,     1'b1,  0,  5,  32'd6,     32'd65541, 1'b1};
    vt[7] = '{1'b0,  0, 0,     1'b1, 10,  7,  32'd0,     32'd7,     1'b1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    s_drive(0, 0, 0, 0, 0, 0);

    // ---------------- reset and init sweep
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl_main", 64'(m_ctl), 64'd0);
    chk("rst_ctl_small", 64'(sa_ctl), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ctl_main", 64'(m_ctl), 64'd0);
    chk("post_rst_ctl_small", 64'(sa_ctl), 64'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk($sformatf("init_w_k%0d", k),
          {w0_val, 2'b0, w0_addr, w0_data, w1_val, 2'b0, w1_addr, 16'h0},
          {1'b1, 2'b0, AW'(2 * k), 32'd0, 1'b1, 2'b0, AW'(2 * k + 1), 16'h0});
      chk($sformatf("init_w1data_k%0d", k), 64'(w1_data), 64'd0);
      chk($sformatf("init_busy_k%0d", k), {in0_rdy, in1_rdy, r0_val, r1_val, init_done}, 64'd0);
      if (k < 4) begin
        chk($sformatf("s_init_w0_k%0d", k), {sa_w0_val, sa_w0_addr}, {1'b1, SAW'(2 * k)});
        chk($sformatf("s_init_w1v_k%0d", k), 64'(sa_w1_val), 64'((2 * k + 1) < SD));
        if ((2 * k + 1) < SD) chk($sformatf("s_init_w1a_k%0d", k), 64'(sa_w1_addr), 64'(2 * k + 1));
      end else if (k == 4) begin
        chk("s_init_done", 64'(sa_ctl), 64'b110000001);
      end
    end
    @(negedge clk);
    chk("init_done_main", 64'(m_ctl), 64'b110000001);

    // ---------------- table-driven vectors
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        mrg = vt[i-1].v0 && vt[i-1].v1 && (vt[i-1].a0 == vt[i-1].a1);
        chk($sformatf("vec%0d_out0_val", i-1), 64'(out0_val), 64'(vt[i-1].v0));
        chk($sformatf("vec%0d_out1_val", i-1), 64'(out1_val), 64'(vt[i-1].v1));
        if (vt[i-1].v0) begin
          chk($sformatf("vec%0d_out0_data", i-1), 64'(out0_data), 64'(vt[i-1].e0));
          chk($sformatf("vec%0d_w0_data", i-1), 64'(w0_data), mrg ? 64'(vt[i-1].e1) : 64'(vt[i-1].e0));
        end
        if (vt[i-1].v1) chk($sformatf("vec%0d_out1_data", i-1), 64'(out1_data), 64'(vt[i-1].e1));
        chk($sformatf("vec%0d_w1_val", i-1), 64'(w1_val), 64'(vt[i-1].ew1));
      end
      if (i < NV) begin
        drive(vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1);
        #1;
        chk($sformatf("vec%0d_rd", i), {r0_val, r1_val}, {vt[i].v0, vt[i].v1});
        if (vt[i].v0) chk($sformatf("vec%0d_r0_addr", i), 64'(r0_addr), 64'(vt[i].a0));
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
    end

    // ---------------- back-to-back on one address
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("b2b_out0_%0d", i), {out0_val, out0_data}, {1'b1, 32'(i)});
      if (i < 4) drive(1, 7, 1, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    chk("b2b_ram7", 64'(ram_m[7]), 64'd4);

    // ---------------- cross-lane forwarding
    @(negedge clk); drive(1, 9, 10, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 9, 5);
    chk("xl_out0", {out0_val, out0_data}, {1'b1, 32'd10});
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("xl_out1", {out1_val, out1_data}, {1'b1, 32'd15});
    chk("xl_w1", {w1_val, 2'b0, w1_addr, w1_data}, {1'b1, 2'b0, AW'(9), 32'd15});

    // ---------------- same-cycle merge on a preloaded counter
    @(negedge clk); poke_en = 1'b1; poke_addr = AW'(2); poke_data = 32'd100;
    @(negedge clk); poke_en = 1'b0;
    @(negedge clk); drive(1, 2, 4, 1, 2, 6);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("mrg_out0", {out0_val, out0_data}, {1'b1, 32'd104});
    chk("mrg_out1", {out1_val, out1_data}, {1'b1, 32'd110});
    chk("mrg_w0", {w0_val, 2'b0, w0_addr, w0_data}, {1'b1, 2'b0, AW'(2), 32'd110});
    chk("mrg_w1_val", 64'(w1_val), 64'd0);

    // ---------------- saturate versus wrap at 8 bits
    @(negedge clk); s_poke_en = 1'b1; s_poke_addr = SAW'(3); s_poke_data = 8'd250;
    @(negedge clk); s_poke_en = 1'b0;
    @(negedge clk); s_drive(1, 3, 10, 0, 0, 0);
    @(negedge clk); s_drive(0, 0, 0, 1, 3, 1);
    chk("sat_out0", {sa_out0_val, sa_out0_data}, {1'b1, 8'd255});
    chk("wrap_out0", {wr_out0_val, wr_out0_data}, {1'b1, 8'd4});
    @(negedge clk); s_drive(0, 0, 0, 0, 0, 0);
    chk("sat_out1_fwd", {sa_out1_val, sa_out1_data}, {1'b1, 8'd255});
    chk("wrap_out1_fwd", {wr_out1_val, wr_out1_data}, {1'b1, 8'd5});

    // ---------------- reset with requests in flight
    @(negedge clk); drive(1, 20, 1, 1, 21, 2);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); rst = 1'b1;
    #1;
    chk("rst_drop", {out0_val, out1_val, w0_val, w1_val}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_ctl", 64'(m_ctl), 64'd0);
    cyc = 0;
    while (!init_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reinit_cycles", 64'(cyc), 64'd33);
    nz = 0;
    for (int a = 0; a < D; a++) if (ram_m[a] != '0) nz++;
    chk("reinit_zeroed", 64'(nz), 64'd0);

    // ---------------- randomized traffic against an ordered-update model
    for (int a = 0; a < D; a++) mdl[a] = '0;
    p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0;
    for (int c = 0; c <= NR; c++) begin
      @(negedge clk);
      chk("rnd_out0_val", 64'(out0_val), 64'(p0v));
      if (p0v) chk("rnd_out0_data", 64'(out0_data), 64'(p0d));
      chk("rnd_out1_val", 64'(out1_val), 64'(p1v));
      if (p1v) chk("rnd_out1_data", 64'(out1_data), 64'(p1d));
      p0v = 1'b0; p1v = 1'b0;
      if (c < NR) begin
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 3) != 0);
        a0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, D - 1)) : int'($urandom_range(0, 7));
        a1 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, D - 1)) : int'($urandom_range(0, 7));
        d0 = ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 65535));
        d1 = int'($urandom_range(0, 65535));
        drive(v0, a0, d0, v1, a1, d1);
        // Requests in one cycle apply in lane order: lane 0, then lane 1.
        if (v0) begin
          mdl[a0] = mdl[a0] + CW'(d0);
          p0v = 1'b1; p0d = mdl[a0];
        end
        if (v1) begin
          mdl[a1] = mdl[a1] + CW'(d1);
          p1v = 1'b1; p1d = mdl[a1];
        end
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
    end
    repeat (3) @(negedge clk);
    for (int a = 0; a < D; a++) chk($sformatf("rnd_ram_%0d", a), 64'(ram_m[a]), 64'(mdl[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
